// File: rtl/dut_out_packer_if.sv
// AXI-Stream beat channel between the output packer and the XDMA C2H sink.
interface dut_out_packer_if #(
    parameter int unsigned BEAT_W = 512
) ();
    logic [BEAT_W-1:0]   tdata;
    logic [BEAT_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/dut_out_packer.sv
// Buffers wide DUT output frames and replays each one as an optional header beat
// followed by NB data beats on an AXI-Stream channel.
module dut_out_packer #(
    parameter int unsigned DATA_W = 4064,
    parameter int unsigned BEAT_W = 512,
    parameter int unsigned DEPTH  = 4,
    parameter bit          HDR_EN = 1'b1
) (
    input  logic              xdma_clk,
    input  logic              xdma_resetn,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              clear_stats,
    dut_out_packer_if.master  m_axis,
    output logic [31:0]       frame_count,
    output logic [31:0]       drop_count,
    output logic              overflow
);
    localparam int unsigned NB         = (DATA_W + BEAT_W - 1) / BEAT_W;
    localparam int unsigned KW         = BEAT_W / 8;
    localparam int unsigned LAST_BYTES = (DATA_W - (NB - 1) * BEAT_W) / 8;
    localparam int unsigned PAD_W      = NB * BEAT_W;
    localparam int unsigned PW         = $clog2(DEPTH);
    localparam int unsigned CW         = $clog2(DEPTH + 1);
    localparam int unsigned BIW        = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BIW-1:0] LAST_BEAT = BIW'(NB - 1);
    localparam logic [KW-1:0]  LAST_KEEP = {KW{1'b1}} >> (KW - LAST_BYTES);
    localparam logic [15:0]    HDR_MAGIC = 16'hDA7A;

    typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

    state_e         state_q, state_d;
    logic [BIW-1:0] beat_q, beat_d;
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           in_ready_q;
    logic [15:0]    seq_q;
    logic [31:0]    frame_count_q, drop_count_q;
    logic           overflow_q;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [31:0]       tag_q [DEPTH];

    logic accept, drop, tvalid, hs, last_beat, retire;
    logic [31:0]                head_tag;
    logic [NB-1:0][BEAT_W-1:0] beats;
    logic [BEAT_W-1:0]          tdata;
    logic [KW-1:0]              tkeep;

    assign accept    = enable && in_valid && in_ready_q;
    assign drop      = enable && in_valid && !in_ready_q;
    assign tvalid    = (state_q != StIdle);
    assign hs        = tvalid && m_axis.tready;
    assign last_beat = (state_q == StData) && (beat_q == LAST_BEAT);
    assign retire    = hs && last_beat;
    assign count_d   = count_q + CW'(accept) - CW'(retire);

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge xdma_clk) begin
        if (accept) begin
            mem_q[wptr_q] <= in_data;
            tag_q[wptr_q] <= {seq_q, drop_count_q[15:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                beat_d = '0;
                if (count_q != '0) state_d = HDR_EN ? StHdr : StData;
            end
            StHdr: if (hs) state_d = StData;
            StData: if (hs) begin
                if (last_beat) begin
                    beat_d = '0;
                    // Chaining straight into the next frame keeps back-to-back frames bubble-free.
                    if (count_d != '0) state_d = HDR_EN ? StHdr : StData;
                    else               state_d = StIdle;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign head_tag = tag_q[rptr_q];
    assign beats    = PAD_W'(mem_q[rptr_q]);

    always_comb begin
        tdata = '0;
        tkeep = '0;
        unique case (state_q)
            StHdr: begin
                tdata = BEAT_W'({16'(NB), head_tag[15:0], head_tag[31:16], HDR_MAGIC});
                tkeep = '1;
            end
            StData: begin
                tdata = beats[beat_q];
                tkeep = last_beat ? LAST_KEEP : '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
        if (!xdma_resetn) begin
            state_q       <= StIdle;
            beat_q        <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b1;
            seq_q         <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            wptr_q     <= wptr_q + PW'(accept);
            rptr_q     <= rptr_q + PW'(retire);
            count_q    <= count_d;
            // Full is judged from the registered count, so a retiring head frame cannot
            // make room for a frame arriving in the same cycle.
            in_ready_q <= (count_d < CW'(DEPTH));
            seq_q      <= seq_q + 16'(accept);
            if (clear_stats) begin
                frame_count_q <= '0;
                drop_count_q  <= '0;
                overflow_q    <= 1'b0;
            end else begin
                frame_count_q <= frame_count_q + 32'(accept);
                if (drop && (drop_count_q != '1)) drop_count_q <= drop_count_q + 32'd1;
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    assign in_ready      = in_ready_q;
    assign frame_count   = frame_count_q;
    assign drop_count    = drop_count_q;
    assign overflow      = overflow_q;
    assign m_axis.tdata  = tdata;
    assign m_axis.tkeep  = tkeep;
    assign m_axis.tlast  = last_beat;
    assign m_axis.tvalid = tvalid;
endmodule
